// File: rtl/huffman_enc_param.sv
// huffman_enc_param: symbol histogram plus iterative two-minimum Huffman code builder.
// Optional macro HUFF_SAT_EN: histogram counts saturate instead of wrapping.
module huffman_enc_param #(
    parameter int NSYM   = 6,
    parameter int CW     = 8,
    parameter int CODE_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   gray_valid,
    input  logic [7:0]             gray_data,
    output logic                   CNT_valid,
    output logic [NSYM*CW-1:0]     CNT,
    output logic                   code_valid,
    output logic [NSYM*CODE_W-1:0] HC,
    output logic [NSYM*CODE_W-1:0] M
);
    localparam int IW = $clog2(NSYM);
    localparam int WW = CW + 3;
    typedef enum logic [2:0] {IDLE, COUNT, INIT, FIND, MERGE, DONE} state_t;
    state_t            state;
    logic [CW-1:0]     cnt    [NSYM];
    logic [IW-1:0]     gid    [NSYM];
    logic [IW-1:0]     len    [NSYM];
    logic [CODE_W-1:0] hc     [NSYM];
    logic [WW-1:0]     wt     [NSYM];
    logic [IW-1:0]     len_nx [NSYM];
    logic [CODE_W-1:0] hc_nx  [NSYM];
    logic [NSYM-1:0]   act;
    logic [IW-1:0]     mcnt, min1, min2, f1, f2, rep, drop;
    logic              h1, h2;
    for (genvar g = 0; g < NSYM; g++) begin : g_cnt
        assign CNT[g*CW +: CW] = cnt[g];
    end
    // Ascending scan with <= lets the higher group id win weight ties.
    always_comb begin
        f1 = '0;
        f2 = '0;
        h1 = 1'b0;
        h2 = 1'b0;
        for (int j = 0; j < NSYM; j++) begin
            if (act[j]) begin
                if (!h1 || wt[j] <= wt[f1]) begin
                    f2 = f1;
                    h2 = h1;
                    f1 = IW'(j);
                    h1 = 1'b1;
                end else if (!h2 || wt[j] <= wt[f2]) begin
                    f2 = IW'(j);
                    h2 = 1'b1;
                end
            end
        end
    end
    always_comb begin
        rep  = (min1 < min2) ? min1 : min2;
        drop = (min1 < min2) ? min2 : min1;
        for (int i = 0; i < NSYM; i++) begin
            hc_nx[i]  = (gid[i] == min1) ? hc[i] | (CODE_W'(1) << len[i]) : hc[i];
            len_nx[i] = (gid[i] == min1 || gid[i] == min2) ? len[i] + 1'b1 : len[i];
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            CNT_valid  <= 1'b0;
            code_valid <= 1'b0;
            HC         <= '0;
            M          <= '0;
            act        <= '0;
            mcnt       <= '0;
            min1       <= '0;
            min2       <= '0;
            for (int i = 0; i < NSYM; i++) begin
                cnt[i] <= '0;
                gid[i] <= '0;
                len[i] <= '0;
                hc[i]  <= '0;
                wt[i]  <= '0;
            end
        end else begin
            CNT_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (gray_valid) begin
                        for (int i = 0; i < NSYM; i++)
                            cnt[i] <= (gray_data == 8'(i + 1)) ? CW'(1) : '0;
                        code_valid <= 1'b0;
                        state      <= COUNT;
                    end
                end
                COUNT: begin
                    if (gray_valid) begin
                        for (int i = 0; i < NSYM; i++)
                            if (gray_data == 8'(i + 1))
`ifdef HUFF_SAT_EN
                                cnt[i] <= (&cnt[i]) ? cnt[i] : cnt[i] + 1'b1;
`else
                                cnt[i] <= cnt[i] + 1'b1;
`endif
                    end else begin
                        CNT_valid <= 1'b1;
                        state     <= INIT;
                    end
                end
                INIT: begin
                    for (int i = 0; i < NSYM; i++) begin
                        gid[i] <= IW'(i);
                        wt[i]  <= WW'(cnt[i]);
                        hc[i]  <= '0;
                        len[i] <= '0;
                    end
                    act   <= '1;
                    mcnt  <= IW'(NSYM - 1);
                    state <= FIND;
                end
                FIND: begin
                    min1  <= f1;
                    min2  <= f2;
                    state <= MERGE;
                end
                MERGE: begin
                    for (int i = 0; i < NSYM; i++) begin
                        hc[i]  <= hc_nx[i];
                        len[i] <= len_nx[i];
                        if (gid[i] == min1 || gid[i] == min2) gid[i] <= rep;
                    end
                    wt[rep]   <= wt[min1] + wt[min2];
                    act[drop] <= 1'b0;
                    mcnt      <= mcnt - 1'b1;
                    if (mcnt == IW'(1)) begin
                        code_valid <= 1'b1;
                        state      <= DONE;
                        for (int i = 0; i < NSYM; i++) begin
                            HC[i*CODE_W +: CODE_W] <= hc_nx[i];
                            M[i*CODE_W +: CODE_W]  <= ~({CODE_W{1'b1}} << len_nx[i]);
                        end
                    end else begin
                        state <= FIND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_huffman_enc_param.sv
// tb_huffman_enc_param: directed frames on NSYM=6 and NSYM=4 encoders, queue scoreboard.
module tb_huffman_enc_param;
    typedef struct packed {
        logic        chk;
        logic [47:0] hc;
        logic [47:0] m;
    } code_t;
    logic        clk, reset;
    logic        gv6, gv4, cv6, cv4, code6, code4;
    logic [7:0]  gd6, gd4;
    logic [47:0] cnt6, hc6, m6;
    logic [31:0] cnt4, hc4, m4;
    logic [47:0] nq6[$], nq4[$];
    code_t       cq6[$], cq4[$];
    logic [7:0]  stim[$];
    int          total, bad, cyc;

    huffman_enc_param #(.NSYM(6), .CW(8), .CODE_W(8)) u6 (
        .clk(clk), .reset(reset), .gray_valid(gv6), .gray_data(gd6),
        .CNT_valid(cv6), .CNT(cnt6), .code_valid(code6), .HC(hc6), .M(m6));
    huffman_enc_param #(.NSYM(4), .CW(8), .CODE_W(8)) u4 (
        .clk(clk), .reset(reset), .gray_valid(gv4), .gray_data(gd4),
        .CNT_valid(cv4), .CNT(cnt4), .code_valid(code4), .HC(hc4), .M(m4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [47:0] a, input logic [47:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic fail_evt(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got output event want none queued", nm);
    endtask

    // Scoreboard monitors: CNT checked on the CNT_valid pulse, codes on the code_valid rise.
    initial begin : mon6
        int t0;
        logic d;
        code_t e;
        t0 = 0;
        d  = 1'b0;
        forever begin
            @(negedge clk);
            if (cv6) begin
                t0 = cyc;
                if (nq6.size() == 0) fail_evt("cnt6");
                else chk("cnt6", cnt6, nq6.pop_front());
            end
            if (code6 && !d) begin
                chk("latency6", 48'(cyc - t0), 48'd11);
                if (cq6.size() == 0) fail_evt("code6");
                else begin
                    e = cq6.pop_front();
                    if (e.chk) begin
                        chk("hc6", hc6, e.hc);
                        chk("m6", m6, e.m);
                    end
                end
            end
            d = code6;
        end
    end

    initial begin : mon4
        int t0;
        logic d;
        code_t e;
        t0 = 0;
        d  = 1'b0;
        forever begin
            @(negedge clk);
            if (cv4) begin
                t0 = cyc;
                if (nq4.size() == 0) fail_evt("cnt4");
                else chk("cnt4", 48'(cnt4), nq4.pop_front());
            end
            if (code4 && !d) begin
                chk("latency4", 48'(cyc - t0), 48'd7);
                if (cq4.size() == 0) fail_evt("code4");
                else begin
                    e = cq4.pop_front();
                    chk("hc4", 48'(hc4), e.hc);
                    chk("m4", 48'(m4), e.m);
                end
            end
            d = code4;
        end
    end

    task automatic send(input bit d6, input logic [7:0] s[$], input bit hold,
                        input logic [47:0] hh, input logic [47:0] hm);
        for (int i = 0; i <= s.size(); i++) begin
            @(posedge clk);
            #1;
            if (i > 0) begin
                chk("code_valid low in frame", 48'(d6 ? code6 : code4), 48'd0);
                if (hold) begin
                    chk("hc held", hc6, hh);
                    chk("m held", m6, hm);
                end
            end
            if (d6) begin
                gv6 = (i < s.size());
                if (i < s.size()) gd6 = s[i];
                else gd6 = 8'd0;
            end else begin
                gv4 = (i < s.size());
                if (i < s.size()) gd4 = s[i];
                else gd4 = 8'd0;
            end
        end
        @(posedge clk);
        #1;
        chk("CNT_valid timing", 48'(d6 ? cv6 : cv4), 48'd1);
    endtask

    task automatic wait_code(input bit d6);
        int n;
        n = 0;
        while (!(d6 ? code6 : code4) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("code_valid arrives", 48'(d6 ? code6 : code4), 48'd1);
        @(negedge clk);
    endtask

    task automatic mk_geo(input bit junk);
        stim = {};
        for (int k = 1; k <= 6; k++)
            for (int r = 0; r < (1 << (k - 1)); r++) begin
                stim.push_back(8'(k));
                if (junk && r == 0) stim.push_back((k == 1) ? 8'd0 : (k == 2) ? 8'd7 : 8'd255);
            end
    endtask

    localparam logic [47:0] GEO_CNT = 48'h2010_0804_0201;
    localparam logic [47:0] GEO_HC  = 48'h0002_060E_1E1F;
    localparam logic [47:0] GEO_M   = 48'h0103_070F_1F1F;
    localparam logic [47:0] TIE_HC  = 48'h0F0E_0602_0100;
    localparam logic [47:0] TIE_M   = 48'h0F0F_0703_0303;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        reset = 1'b0;
        gv6 = 1'b0; gd6 = 8'd0; gv4 = 1'b0; gd4 = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset cnt", cnt6, 48'd0);
        chk("reset hc", hc6, 48'd0);
        chk("reset m", m6, 48'd0);
        chk("reset flags", {46'd0, cv6, code6}, 48'd0);
        reset = 1'b1;
        // Geometric frame
        mk_geo(1'b0);
        nq6.push_back(GEO_CNT);
        cq6.push_back({1'b1, GEO_HC, GEO_M});
        send(1'b1, stim, 1'b0, '0, '0);
        wait_code(1'b1);
        // Same frame with invalid symbols, back-to-back from DONE
        mk_geo(1'b1);
        nq6.push_back(GEO_CNT);
        cq6.push_back({1'b1, GEO_HC, GEO_M});
        send(1'b1, stim, 1'b1, GEO_HC, GEO_M);
        wait_code(1'b1);
        // Tie-break stream on NSYM=6: symbols 5 and 6 carry weight 0
        stim = {8'd1, 8'd2, 8'd3, 8'd4};
        nq6.push_back(48'h0000_0101_0101);
        cq6.push_back({1'b1, TIE_HC, TIE_M});
        send(1'b1, stim, 1'b1, GEO_HC, GEO_M);
        wait_code(1'b1);
        // Overflow on symbol 1
        stim = {};
        repeat (300) stim.push_back(8'd1);
`ifdef HUFF_SAT_EN
        nq6.push_back(48'h0000_0000_00FF);
`else
        nq6.push_back(48'h0000_0000_002C);
`endif
        cq6.push_back({1'b0, 48'd0, 48'd0});
        send(1'b1, stim, 1'b1, TIE_HC, TIE_M);
        wait_code(1'b1);
        // Abort in MERGE with asynchronous reset
        mk_geo(1'b0);
        nq6.push_back(GEO_CNT);
        send(1'b1, stim, 1'b0, '0, '0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort cnt", cnt6, 48'd0);
        chk("abort hc", hc6, 48'd0);
        chk("abort m", m6, 48'd0);
        chk("abort flags", {46'd0, cv6, code6}, 48'd0);
        @(negedge clk);
        reset = 1'b1;
        nq6.push_back(GEO_CNT);
        cq6.push_back({1'b1, GEO_HC, GEO_M});
        send(1'b1, stim, 1'b0, '0, '0);
        wait_code(1'b1);
        // Tie-break on NSYM=4
        stim = {8'd1, 8'd2, 8'd3, 8'd4};
        nq4.push_back(48'h0101_0101);
        cq4.push_back({1'b1, 48'h0302_0100, 48'h0303_0303});
        send(1'b0, stim, 1'b0, '0, '0);
        wait_code(1'b0);
        repeat (2) @(negedge clk);
        chk("cnt6 queue drained", 48'(nq6.size()), 48'd0);
        chk("code6 queue drained", 48'(cq6.size()), 48'd0);
        chk("cnt4 queue drained", 48'(nq4.size()), 48'd0);
        chk("code4 queue drained", 48'(cq4.size()), 48'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/huffman_enc_param.md
Name: huffman_enc_param

Overview:
Parametrised successor of the team's 6-symbol Huffman encoder. It counts a stream of symbol values, then builds a Huffman code tree by iterative two-minimum merges, and outputs per-symbol histogram counts, code words and code masks. It supports NSYM symbols and CW-bit counts, and accepts back-to-back frames without reset. It sits between the image/gray-level source and the entropy-packing stage.

Parameters:
NSYM, 6, number of symbols (2..8); valid symbol values are 1..NSYM.
CW, 8, width of each histogram count.
CODE_W, 8, width of each code/mask field; must be >= NSYM-1.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous reset, active-low
gray_valid  in  1  gray_data is valid this cycle; asserted contiguously for one frame
gray_data  in  8  symbol value; values 0 or >NSYM are ignored
CNT_valid  out  1  one-cycle pulse; CNT bus is final for the frame
CNT  out  NSYM*CW  count of symbol k in bits [k*CW-1:(k-1)*CW]
code_valid  out  1  HC/M are valid; held high until the next frame starts
HC  out  NSYM*CODE_W  code of symbol k, LSB-aligned, in field k
M  out  NSYM*CODE_W  mask of symbol k: code-length ones, LSB-aligned

Behaviour:
- Reset (reset=0, async) sets the FSM to IDLE and clears all outputs, internal counts, group ids and lengths.
- FSM states are IDLE, COUNT, INIT, FIND, MERGE and DONE.
- IDLE: on gray_valid=1, go to COUNT; that cycle's sample is counted.
- COUNT: on each cycle with gray_valid=1, increment the CNT field for gray_data. When gray_valid=0, go to INIT.
- Count arithmetic: wraps modulo 2^CW (see the optional feature).
- INIT (1 cycle): CNT_valid=1 this cycle only.
  - Group id of symbol k = k.
  - Group weight = CNT_k, held in CW+3 bits.
  - HC=0 and length=0 for every symbol.
  - merge counter = NSYM-1.
- FIND (1 cycle): combinationally select the active groups min1 (smallest weight) and min2 (second smallest) and register them.
  - Tie rule: for equal weights, the group with the larger representative id ranks smaller.
  - Representative id = lowest symbol index in the group.
- MERGE (1 cycle): update every symbol in min1 or min2.
  - Code update: HC |= bit << length, then length++.
  - The bit is 1 for members of min1 and 0 for members of min2.
  - Surviving group id = min(rep1, rep2); its weight = w1 + w2. The other group is deactivated.
  - Decrement the merge counter. If it reaches 0, go to DONE; otherwise go to FIND.
- Total latency from the INIT cycle to code_valid is 2*(NSYM-1)+1 cycles.
- DONE: code_valid=1. M field k = (1<<length_k)-1.
- gray_valid=1 while in DONE starts a new frame, with these actions in the same cycle:
  - clear all counts, then count that sample;
  - drop code_valid to 0;
  - hold HC/M at their old values until the next DONE;
  - go to COUNT.
- gray_valid=1 during INIT, FIND or MERGE is ignored; the frame is lost. Benches must not do this.
- Zero-count symbols participate normally, with weight 0.
- A single-sample frame (gray_valid high for 1 cycle) is legal.
- Reset mid-frame or mid-merge aborts the operation. All outputs return to 0 asynchronously.

Optional Feature:
HUFF_SAT_EN
- Defined: each CNT field saturates at 2^CW-1, and further samples of that symbol are dropped.
- Undefined: fields wrap modulo 2^CW. Merge weights use the stored (wrapped) value.

Test Plan:
- Geometric frame, NSYM=6: counts A1..A6 = 1,2,4,8,16,32 (63 samples).
  - CNT_valid pulses 1 cycle after gray_valid falls, with CNT = 1,2,4,8,16,32.
  - HC = 0x1F,0x1E,0x0E,0x06,0x02,0x00.
  - M = 0x1F,0x1F,0x0F,0x07,0x03,0x01.
- Tie-break, NSYM=4: one sample each of 1,2,3,4 -> HC = 0,1,2,3; all M = 0x3.
- Invalid symbols: 0, 7, 255 interleaved in the geometric frame -> identical CNT/HC/M to the geometric case.
- Back-to-back frames: DONE, then the tie-break stream.
  - code_valid falls on the first new sample.
  - Second results appear with no reset.
- Overflow: 300 samples of symbol 1.
  - HUFF_SAT_EN defined: CNT1 = 255.
  - HUFF_SAT_EN undefined: CNT1 = 44.
- Reset asserted during a MERGE state -> all outputs 0 immediately; a following geometric frame gives the geometric results.
